// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch program-counter unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_t;

  localparam int          PC_STEP          = 4;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

endpackage

// File: rtl/fetch_pc_unit.sv
// Program counter and single-outstanding instruction-fetch sequencer. The PC+4 adder
// lives outside this block: o_pc feeds it and i_pc_plus4 returns the sequential PC.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready are both
// high. A source holds valid until the transfer, except that a redirect may retarget an
// unaccepted imem request and drops an instruction waiting for decode. i_rsp_valid is a
// one-cycle pulse with no ready; it is only legal while a request is outstanding.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 64,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  output logic [ADDR_WIDTH-1:0]  o_pc,
  input  logic [ADDR_WIDTH-1:0]  i_pc_plus4,
  input  logic                   i_redirect,
  input  logic [ADDR_WIDTH-1:0]  i_redirect_target,
  output logic                   o_req_valid,
  input  logic                   i_req_ready,
  output logic [ADDR_WIDTH-1:0]  o_req_addr,
  input  logic                   i_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] i_rsp_instr,
  output logic                   o_instr_valid,
  input  logic                   i_dec_ready,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0]  o_instr_pc,
  output logic                   o_misaligned,
  output logic [1:0]             o_dbg_state
);

  fetch_state_t           state, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic                   kill_q, kill_d;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [ADDR_WIDTH-1:0]  instr_pc_q;
  logic                   misaligned_q;
  logic                   capture;
  logic                   redirect_ok;
  logic                   redirect_bad;

  assign redirect_ok  = i_redirect && (i_redirect_target[1:0] == 2'b00);
  assign redirect_bad = i_redirect && (i_redirect_target[1:0] != 2'b00);

  assign o_pc          = pc_q;
  assign o_req_addr    = pc_q;
  assign o_req_valid   = (state == S_REQ);
  // A redirect in the same cycle must stop decode from taking a wrong-path word.
  assign o_instr_valid = (state == S_HOLD) && !redirect_ok;
  assign o_instr       = instr_q;
  assign o_instr_pc    = instr_pc_q;
  assign o_misaligned  = misaligned_q;
  assign o_dbg_state   = state;

  always_comb begin
    state_d = state;
    pc_d    = pc_q;
    kill_d  = kill_q;
    capture = 1'b0;
    unique case (state)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect_ok) pc_d = i_redirect_target;
      end
      S_REQ: begin
        if (i_req_ready) state_d = S_WAIT;
        if (redirect_ok) begin
          pc_d = i_redirect_target;
          // The accepted request carried the old PC, so its response must be discarded.
          if (i_req_ready) kill_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (redirect_ok) begin
          pc_d = i_redirect_target;
          if (i_rsp_valid) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            kill_d = 1'b1;
          end
        end else if (i_rsp_valid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            capture = 1'b1;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect_ok) begin
          pc_d    = i_redirect_target;
          state_d = S_REQ;
        end else if (i_dec_ready) begin
          pc_d    = i_pc_plus4;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state        <= S_IDLE;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      instr_q      <= '0;
      instr_pc_q   <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state        <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      misaligned_q <= redirect_bad;
      if (capture) begin
        instr_q    <= i_rsp_instr;
        instr_pc_q <= pc_q;
      end
    end
  end

  // Only one request may be outstanding, so a response outside S_WAIT is an imem bug.
  a_rsp_only_in_wait: assert property (@(posedge i_clk) disable iff (i_arst)
    i_rsp_valid |-> (state == S_WAIT));

  a_adder_step: assert property (@(posedge i_clk) disable iff (i_arst)
    (state == S_HOLD && i_dec_ready && !redirect_ok) |->
      (i_pc_plus4 == pc_q + ADDR_WIDTH'(PC_STEP)));

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Cycle-by-cycle vector bench for fetch_pc_unit, plus a hand-written mid-fetch reset.
`timescale 1ns/1ps
module tb_fetch_pc_unit;

  localparam int AW = 64;
  localparam int IW = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  localparam logic [IW-1:0] W0 = 32'h1111_0000;
  localparam logic [IW-1:0] W4 = 32'h2222_0004;
  localparam logic [IW-1:0] W8 = 32'h3333_0008;
  localparam logic [IW-1:0] B0 = 32'h4444_0100;
  localparam logic [IW-1:0] C0 = 32'h5555_0200;
  localparam logic [IW-1:0] C4 = 32'h6666_0204;
  localparam logic [IW-1:0] DD = 32'h7777_0208;
  localparam logic [IW-1:0] EE = 32'h8888_FFFC;
  localparam logic [IW-1:0] FF = 32'h9999_0000;
  localparam logic [AW-1:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

  // clock / reset
  logic          clk = 1'b0;
  logic          arst;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_plus4;
  logic          redirect;
  logic [AW-1:0] redirect_target;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          rsp_valid;
  logic [IW-1:0] rsp_instr;
  logic          instr_valid;
  logic          dec_ready;
  logic [IW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          misaligned;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  // External PC+4 adder that sits beside the unit; carry-out is discarded.
  assign pc_plus4 = pc + 64'd4;

  fetch_pc_unit #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .RESET_PC(64'h0)) dut (
    .i_clk(clk), .i_arst(arst), .o_pc(pc), .i_pc_plus4(pc_plus4),
    .i_redirect(redirect), .i_redirect_target(redirect_target),
    .o_req_valid(req_valid), .i_req_ready(req_ready), .o_req_addr(req_addr),
    .i_rsp_valid(rsp_valid), .i_rsp_instr(rsp_instr),
    .o_instr_valid(instr_valid), .i_dec_ready(dec_ready), .o_instr(instr),
    .o_instr_pc(instr_pc), .o_misaligned(misaligned), .o_dbg_state(dbg_state)
  );

  typedef struct {
    logic          redir;
    logic [AW-1:0] tgt;
    logic          rdy;
    logic          rspv;
    logic [IW-1:0] rspd;
    logic          dec;
    logic [1:0]    e_st;
    logic          e_reqv;
    logic [AW-1:0] e_addr;
    logic          e_insv;
    logic [IW-1:0] e_ins;
    logic [AW-1:0] e_inspc;
    logic          e_mis;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic redir, logic [AW-1:0] tgt, logic rdy, logic rspv,
                              logic [IW-1:0] rspd, logic dec, logic [1:0] e_st,
                              logic e_reqv, logic [AW-1:0] e_addr, logic e_insv,
                              logic [IW-1:0] e_ins, logic [AW-1:0] e_inspc, logic e_mis);
    vec_t v;
    v.redir = redir; v.tgt = tgt; v.rdy = rdy; v.rspv = rspv; v.rspd = rspd; v.dec = dec;
    v.e_st = e_st; v.e_reqv = e_reqv; v.e_addr = e_addr; v.e_insv = e_insv;
    v.e_ins = e_ins; v.e_inspc = e_inspc; v.e_mis = e_mis;
    return v;
  endfunction

  // scoreboard compare
  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    redirect        = v.redir;
    redirect_target = v.tgt;
    req_ready       = v.rdy;
    rsp_valid       = v.rspv;
    rsp_instr       = v.rspd;
    dec_ready       = v.dec;
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    chk({tag, " state"},       AW'(dbg_state),   AW'(v.e_st));
    chk({tag, " req_valid"},   AW'(req_valid),   AW'(v.e_reqv));
    chk({tag, " req_addr"},    req_addr,         v.e_addr);
    chk({tag, " pc"},          pc,               v.e_addr);
    chk({tag, " instr_valid"}, AW'(instr_valid), AW'(v.e_insv));
    chk({tag, " instr"},       AW'(instr),       AW'(v.e_ins));
    chk({tag, " instr_pc"},    instr_pc,         v.e_inspc);
    chk({tag, " misaligned"},  AW'(misaligned),  AW'(v.e_mis));
  endtask

  task automatic idle_inputs();
    redirect = 1'b0; redirect_target = '0; req_ready = 1'b1;
    rsp_valid = 1'b0; rsp_instr = '0; dec_ready = 1'b1;
  endtask

  initial begin
    vec_t v;
    //           redir tgt     rdy rspv rspd dec   state    reqv addr    insv ins inspc    mis
    // 0x0, 0x4 fetched in order with one-cycle imem latency
    vecs.push_back(mk(0, 0,      1, 0, 0,  1,  ST_IDLE, 0, 0,      0, 0,  0,      0));
    vecs.push_back(mk(0, 0,      1, 0, 0,  1,  ST_REQ,  1, 0,      0, 0,  0,      0));
    vecs.push_back(mk(0, 0,      1, 1, W0, 1,  ST_WAIT, 0, 0,      0, 0,  0,      0));
    vecs.push_back(mk(0, 0,      1, 0, 0,  1,  ST_HOLD, 0, 0,      1, W0, 0,      0));
    vecs.push_back(mk(0, 0,      1, 0, 0,  1,  ST_REQ,  1, 4,      0, W0, 0,      0));
    vecs.push_back(mk(0, 0,      1, 1, W4, 1,  ST_WAIT, 0, 4,      0, W0, 0,      0));
    vecs.push_back(mk(0, 0,      1, 0, 0,  1,  ST_HOLD, 0, 4,      1, W4, 4,      0));
    vecs.push_back(mk(0, 0,      1, 0, 0,  1,  ST_REQ,  1, 8,      0, W4, 4,      0));
    // redirect to 0x100 while waiting for 0x8: word for 0x8 dropped
    vecs.push_back(mk(1, 'h100,  1, 0, 0,  1,  ST_WAIT, 0, 8,      0, W4, 4,      0));
    vecs.push_back(mk(0, 0,      1, 1, W8, 1,  ST_WAIT, 0, 'h100,  0, W4, 4,      0));
    vecs.push_back(mk(0, 0,      1, 0, 0,  1,  ST_REQ,  1, 'h100,  0, W4, 4,      0));
    vecs.push_back(mk(0, 0,      1, 1, B0, 1,  ST_WAIT, 0, 'h100,  0, W4, 4,      0));
    // decode stalls 5 cycles: instruction held, no request
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0,    1, 0, 0,  0,  ST_HOLD, 0, 'h100,  1, B0, 'h100,  0));
    // redirect to 0x200 together with dec_ready: instruction not handed over
    vecs.push_back(mk(1, 'h200,  1, 0, 0,  1,  ST_HOLD, 0, 'h100,  0, B0, 'h100,  0));
    vecs.push_back(mk(0, 0,      0, 0, 0,  1,  ST_REQ,  1, 'h200,  0, B0, 'h100,  0));
    vecs.push_back(mk(0, 0,      1, 0, 0,  1,  ST_REQ,  1, 'h200,  0, B0, 'h100,  0));
    vecs.push_back(mk(0, 0,      1, 1, C0, 1,  ST_WAIT, 0, 'h200,  0, B0, 'h100,  0));
    vecs.push_back(mk(0, 0,      1, 0, 0,  1,  ST_HOLD, 0, 'h200,  1, C0, 'h200,  0));
    // misaligned redirect to 0x102: ignored, one-cycle pulse next cycle
    vecs.push_back(mk(1, 'h102,  1, 0, 0,  1,  ST_REQ,  1, 'h204,  0, C0, 'h200,  0));
    vecs.push_back(mk(0, 0,      1, 1, C4, 1,  ST_WAIT, 0, 'h204,  0, C0, 'h200,  1));
    vecs.push_back(mk(0, 0,      1, 0, 0,  1,  ST_HOLD, 0, 'h204,  1, C4, 'h204,  0));
    // redirect on the same edge the request is accepted: its response is killed
    vecs.push_back(mk(1, 'h300,  1, 0, 0,  1,  ST_REQ,  1, 'h208,  0, C4, 'h204,  0));
    vecs.push_back(mk(0, 0,      1, 1, DD, 1,  ST_WAIT, 0, 'h300,  0, C4, 'h204,  0));
    // redirect retargets an unaccepted request to the top of the address space
    vecs.push_back(mk(1, TOP,    0, 0, 0,  1,  ST_REQ,  1, 'h300,  0, C4, 'h204,  0));
    vecs.push_back(mk(0, 0,      1, 0, 0,  1,  ST_REQ,  1, TOP,    0, C4, 'h204,  0));
    vecs.push_back(mk(0, 0,      1, 1, EE, 1,  ST_WAIT, 0, TOP,    0, C4, 'h204,  0));
    vecs.push_back(mk(0, 0,      1, 0, 0,  1,  ST_HOLD, 0, TOP,    1, EE, TOP,    0));
    // PC wraps to 0x0
    vecs.push_back(mk(0, 0,      1, 0, 0,  1,  ST_REQ,  1, 0,      0, EE, TOP,    0));
    // redirect coinciding with a response in S_WAIT: word dropped, go fetch target
    vecs.push_back(mk(1, 'h400,  1, 1, FF, 1,  ST_WAIT, 0, 0,      0, EE, TOP,    0));
    vecs.push_back(mk(0, 0,      1, 0, 0,  1,  ST_REQ,  1, 'h400,  0, EE, TOP,    0));
    vecs.push_back(mk(0, 0,      1, 0, 0,  1,  ST_WAIT, 0, 'h400,  0, EE, TOP,    0));

    // reset state
    arst = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    v = mk(0, 0, 1, 0, 0, 1, ST_IDLE, 0, 0, 0, 0, 0, 0);
    check_outputs("reset", v);
    @(posedge clk);
    #1 arst = 1'b0;

    // vector table: drive after the edge, compare on the falling edge
    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(negedge clk);
      check_outputs($sformatf("vec%0d", i), vecs[i]);
      @(posedge clk);
      #1;
    end

    // reset asserted while a request is outstanding
    idle_inputs();
    chk("pre_reset state", AW'(dbg_state), AW'(ST_WAIT));
    #2 arst = 1'b1;
    #1;
    v = mk(0, 0, 1, 0, 0, 1, ST_IDLE, 0, 0, 0, 0, 0, 0);
    check_outputs("midreset", v);
    @(negedge clk);
    rsp_valid = 1'b1;
    rsp_instr = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 rsp_valid = 1'b0;
    @(negedge clk);
    check_outputs("after_rsp_in_reset", v);
    @(posedge clk);
    #1 arst = 1'b0;
    @(negedge clk);
    check_outputs("release0", v);
    @(posedge clk);
    #1;
    @(negedge clk);
    v = mk(0, 0, 1, 0, 0, 1, ST_REQ, 1, 0, 0, 0, 0, 0);
    check_outputs("release1", v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
